can_form_checker: RTL and testbench

- Parametrised CAN form-error detector for the bit-stream receive path.
- Checks every fixed-form bit for a dominant (0) level at the sample point: CRC delimiter, ACK delimiter, and the first EOF_CHECK_BITS bits of End-of-Frame.
- On a violation it raises a stretched error flag, latches which field failed, and counts errors.
- Sits beside the bit-destuffer/field decoder and feeds the error-frame generator and the error counters.

---
 rtl/can_pkg.sv | 26 ++
 rtl/can_sample_pipe.sv | 31 +++
 rtl/can_form_checker.sv | 118 +++++++++++
 tb/tb_can_form_checker.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared CAN frame-field codes and monitor state types for the bit-level receive path.
package can_pkg;

  localparam int FIELD_W = 5;

  localparam logic [FIELD_W-1:0] FLD_IDLE     = 5'b00000;
  localparam logic [FIELD_W-1:0] FLD_SOF      = 5'b00001;
  localparam logic [FIELD_W-1:0] FLD_ID       = 5'b00010;
  localparam logic [FIELD_W-1:0] FLD_RTR      = 5'b00011;
  localparam logic [FIELD_W-1:0] FLD_IDE      = 5'b00100;
  localparam logic [FIELD_W-1:0] FLD_R0       = 5'b00101;
  localparam logic [FIELD_W-1:0] FLD_DLC      = 5'b00110;
  localparam logic [FIELD_W-1:0] FLD_DATA     = 5'b00111;
  localparam logic [FIELD_W-1:0] FLD_CRC      = 5'b10001;
  localparam logic [FIELD_W-1:0] FLD_CRC_DEL  = 5'b10010;
  localparam logic [FIELD_W-1:0] FLD_ACK_DEL  = 5'b10011;
  localparam logic [FIELD_W-1:0] FLD_EOF      = 5'b10100;
  localparam logic [FIELD_W-1:0] FLD_IFS      = 5'b10101;
  localparam logic [FIELD_W-1:0] FLD_ACK_SLOT = 5'b11000;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/can_sample_pipe.sv
// Delays the sample strobe, bus level and field code together so they stay aligned.
module can_sample_pipe #(
  parameter int FIELD_W = 5,
  parameter int STAGES  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample,
  input  logic               data,
  input  logic [FIELD_W-1:0] field,
  output logic               sample_dly,
  output logic               data_dly,
  output logic [FIELD_W-1:0] field_dly
);

  localparam int W = FIELD_W + 2;

  logic [W-1:0] stage [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= {sample, data, field};
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign {sample_dly, data_dly, field_dly} = stage[STAGES-1];

endmodule

// File: rtl/can_form_checker.sv
// Flags dominant levels on CAN fixed-form bits (CRC/ACK delimiters, leading EOF bits)
// with a stretched error flag, the failing field code and a saturating error count.
module can_form_checker #(
  parameter int                 FIELD_W        = can_pkg::FIELD_W,
  parameter logic [FIELD_W-1:0] CRC_DEL_CODE   = can_pkg::FLD_CRC_DEL,
  parameter logic [FIELD_W-1:0] ACK_DEL_CODE   = can_pkg::FLD_ACK_DEL,
  parameter logic [FIELD_W-1:0] EOF_CODE       = can_pkg::FLD_EOF,
  parameter int                 EOF_CHECK_BITS = 6,
  parameter int                 DELAY_STAGES   = 2,
  parameter int                 HOLD_CLKS      = 20,
  parameter int                 CNT_W          = 8
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Sample,
  input  logic               i_Data,
  input  logic [FIELD_W-1:0] i_frame_field,
  input  logic               i_Enable,
  input  logic               i_Clear_Count,
  output logic               o_form_error,
  output logic [FIELD_W-1:0] o_error_field,
  output logic [CNT_W-1:0]   o_error_count
);

  import can_pkg::*;

  localparam int EOF_W  = $clog2(EOF_CHECK_BITS + 1);
  localparam int HOLD_W = $clog2(HOLD_CLKS + 1);

  logic               s_smp;
  logic               s_dat;
  logic [FIELD_W-1:0] s_fld;
  logic [EOF_W-1:0]   eof_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  state_t             state;
  logic               is_eof;
  logic               eof_open;
  logic               violation;

  can_sample_pipe #(
    .FIELD_W (FIELD_W),
    .STAGES  (DELAY_STAGES)
  ) u_pipe (
    .clk        (i_Clock),
    .rst        (i_Reset),
    .sample     (i_Sample),
    .data       (i_Data),
    .field      (i_frame_field),
    .sample_dly (s_smp),
    .data_dly   (s_dat),
    .field_dly  (s_fld)
  );

  // The last EOF bit is left unchecked: dominant there means overload, not a form error.
  assign is_eof    = (s_fld == EOF_CODE);
  assign eof_open  = (eof_cnt < EOF_W'(EOF_CHECK_BITS));
  assign violation = s_smp & i_Enable & ~s_dat &
                     ((s_fld == CRC_DEL_CODE) | (s_fld == ACK_DEL_CODE) | (is_eof & eof_open));

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      eof_cnt <= '0;
    end else if (!is_eof) begin
      eof_cnt <= '0;
    end else if (s_smp && eof_open) begin
      eof_cnt <= eof_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_error_count <= '0;
    end else if (i_Clear_Count) begin
      o_error_count <= '0;
    end else if (violation && (o_error_count != '1)) begin
      o_error_count <= o_error_count + 1'b1;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state         <= IDLE;
      o_form_error  <= 1'b0;
      o_error_field <= '0;
      hold_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (violation) begin
            state         <= HOLD;
            o_form_error  <= 1'b1;
            o_error_field <= s_fld;
            hold_cnt      <= '0;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_W'(HOLD_CLKS - 1)) begin
            // A violation on the exit clock opens a fresh window without a gap.
            if (violation) begin
              o_error_field <= s_fld;
              hold_cnt      <= '0;
            end else begin
              state        <= IDLE;
              o_form_error <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          o_form_error <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_form_checker.sv
// Directed bench for can_form_checker: one default instance and one with a 2-bit counter.
module tb_can_form_checker;

  localparam logic [4:0] F_CRC_DEL = 5'b10010;
  localparam logic [4:0] F_ACK_DEL = 5'b10011;
  localparam logic [4:0] F_EOF     = 5'b10100;
  localparam logic [4:0] F_IFS     = 5'b10101;

  logic       clk = 1'b0;
  logic       rst;
  logic       smp;
  logic       dat;
  logic [4:0] fld;
  logic       en;
  logic       clr;

  logic       form_error_a;
  logic [4:0] field_a;
  logic [7:0] cnt_a;
  logic       form_error_b;
  logic [4:0] field_b;
  logic [1:0] cnt_b;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  int hi;

  always #5 clk = ~clk;

  can_form_checker dut_a (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Sample      (smp),
    .i_Data        (dat),
    .i_frame_field (fld),
    .i_Enable      (en),
    .i_Clear_Count (clr),
    .o_form_error  (form_error_a),
    .o_error_field (field_a),
    .o_error_count (cnt_a)
  );

  can_form_checker #(.CNT_W(2)) dut_b (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Sample      (smp),
    .i_Data        (dat),
    .i_frame_field (fld),
    .i_Enable      (en),
    .i_Clear_Count (clr),
    .o_form_error  (form_error_b),
    .o_error_field (field_b),
    .o_error_count (cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [4:0] f, input logic b);
    fld = f;
    dat = b;
    smp = 1'b1;
    tick();
    smp = 1'b0;
    dat = 1'b1;
  endtask

  // Called right after the flag rose; returns how many clocks it stayed high.
  task automatic measure(input int inject_at, input logic [4:0] inj_fld, output int n);
    n = 1;
    for (int k = 0; k < 80; k++) begin
      if (n == inject_at) begin
        fld = inj_fld;
        dat = 1'b0;
        smp = 1'b1;
      end
      tick();
      smp = 1'b0;
      dat = 1'b1;
      if (form_error_a) n++;
      else break;
    end
  endtask

  task automatic eof_run(input int dom_bit);
    fld = F_IFS;
    repeat (5) tick();
    for (int b = 1; b <= 7; b++) begin
      strobe(F_EOF, (b == dom_bit) ? 1'b0 : 1'b1);
      repeat (3) tick();
    end
    repeat (25) tick();
    fld = F_IFS;
    repeat (5) tick();
  endtask

  initial begin
    rst = 1'b1; smp = 1'b0; dat = 1'b1; fld = F_IFS; en = 1'b1; clr = 1'b0;
    repeat (3) tick();
    chk("rst_flag", form_error_a, 1'b0);
    chk("rst_field", field_a, 5'd0);
    chk("rst_cnt", cnt_a, 8'd0);
    chk("rst_cnt_b", cnt_b, 2'd0);
    rst = 1'b0;
    tick();

    // Recessive CRC delimiter is legal
    strobe(F_CRC_DEL, 1'b1);
    repeat (5) tick();
    chk("recessive_flag", form_error_a, 1'b0);
    chk("recessive_cnt", cnt_a, 8'd0);

    // Dominant ACK delimiter: 3-clock latency, 20-clock flag
    strobe(F_ACK_DEL, 1'b0);
    chk("lat_e1", form_error_a, 1'b0);
    tick();
    chk("lat_e2", form_error_a, 1'b0);
    tick();
    chk("lat_e3", form_error_a, 1'b1);
    chk("ack_field", field_a, F_ACK_DEL);
    exp_cnt = 1;
    chk("ack_cnt", cnt_a, exp_cnt);
    measure(0, F_IFS, hi);
    chk("ack_hold_len", hi, 20);
    chk("ack_field_kept", field_a, F_ACK_DEL);

    // EOF: bit 3 dominant flags, bit 7 does not, bit 6 is the last checked
    eof_run(3);
    exp_cnt++;
    chk("eof3_cnt", cnt_a, exp_cnt);
    chk("eof3_field", field_a, F_EOF);
    eof_run(7);
    chk("eof7_cnt", cnt_a, exp_cnt);
    chk("eof7_flag", form_error_a, 1'b0);
    eof_run(6);
    exp_cnt++;
    chk("eof6_cnt", cnt_a, exp_cnt);

    // Second violation inside the hold neither extends nor overwrites
    strobe(F_ACK_DEL, 1'b0);
    repeat (2) tick();
    chk("inhold_rise", form_error_a, 1'b1);
    measure(6, F_CRC_DEL, hi);
    chk("inhold_len", hi, 20);
    chk("inhold_field", field_a, F_ACK_DEL);
    exp_cnt += 2;
    chk("inhold_cnt", cnt_a, exp_cnt);
    repeat (5) tick();

    // Violation landing on the exit clock starts a fresh window back to back
    strobe(F_ACK_DEL, 1'b0);
    repeat (2) tick();
    chk("retrig_rise", form_error_a, 1'b1);
    measure(18, F_CRC_DEL, hi);
    chk("retrig_len", hi, 40);
    chk("retrig_field", field_a, F_CRC_DEL);
    exp_cnt += 2;
    chk("retrig_cnt", cnt_a, exp_cnt);
    repeat (5) tick();

    // Enable low suppresses detection
    en = 1'b0;
    strobe(F_ACK_DEL, 1'b0);
    repeat (5) tick();
    chk("dis_flag", form_error_a, 1'b0);
    chk("dis_cnt", cnt_a, exp_cnt);
    en = 1'b1;

    // Counter clear and saturation on the narrow instance
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_cnt_a", cnt_a, 8'd0);
    chk("clr_cnt_b", cnt_b, 2'd0);
    for (int k = 1; k <= 5; k++) begin
      strobe(F_ACK_DEL, 1'b0);
      repeat (30) tick();
      chk("sat_cnt_a", cnt_a, k);
      chk("sat_cnt_b", cnt_b, (k > 3) ? 3 : k);
    end
    strobe(F_ACK_DEL, 1'b0);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clrprio_cnt_a", cnt_a, 8'd0);
    chk("clrprio_cnt_b", cnt_b, 2'd0);
    chk("clrprio_flag", form_error_a, 1'b1);
    repeat (30) tick();

    // Reset in the middle of a hold
    strobe(F_ACK_DEL, 1'b0);
    repeat (2) tick();
    chk("midrst_rise", form_error_a, 1'b1);
    repeat (7) tick();
    rst = 1'b1;
    #1;
    chk("midrst_flag", form_error_a, 1'b0);
    chk("midrst_field", field_a, 5'd0);
    chk("midrst_cnt", cnt_a, 8'd0);
    repeat (3) tick();
    rst = 1'b0;
    hi = 0;
    repeat (30) begin
      tick();
      if (form_error_a) hi++;
    end
    chk("postrst_highs", hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
